// File: rtl/link_pkg.sv
// Shared types and defaults for the serial frame transmitter.
package link_pkg;

    localparam int unsigned DEF_FRAME_W     = 49;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_INIT_CYCLES = 49;
    localparam int unsigned DEF_GAP_CYCLES  = 0;

    // One counter serves INIT, bit position and gap timing; 8 bits covers all of them.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } link_state_e;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/link_tx_fifo.sv
// Frame FIFO ahead of the shifter; wrapping pointers plus a separate occupancy counter.
module link_tx_fifo
    import link_pkg::*;
#(
    parameter int unsigned W     = DEF_FRAME_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        LINK_CLK,
    input  logic                        RESETN,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                wr_data,
    output logic [W-1:0]                rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_w(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok_c, pop_ok_c;

    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;

    always_ff @(posedge LINK_CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge LINK_CLK) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/link_frame_tx.sv
// Serial frame transmitter: FIFO-buffered frames shifted out LSB-index first with an end-of-frame SYNC.
// Optional even parity bit after the payload when LINK_FRAME_TX_PARITY_EN is defined.
module link_frame_tx
    import link_pkg::*;
#(
    parameter int unsigned FRAME_W     = DEF_FRAME_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                              LINK_CLK,
    input  logic                              RESETN,
    input  logic                              DATA_READY,
    input  logic [FRAME_W-1:0]                TR_DATA,
    output logic                              TR_READY,
    output logic                              S_OUT,
    output logic                              SYNC,
    output logic                              BUSY,
    output logic [level_w(FIFO_DEPTH)-1:0]    LEVEL
);
`ifdef LINK_FRAME_TX_PARITY_EN
    localparam int unsigned FRAME_LEN = FRAME_W + 1;
`else
    localparam int unsigned FRAME_LEN = FRAME_W;
`endif

    link_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic                 s_out_q, s_out_d;
    logic                 sync_q, sync_d;
    logic                 push_c, pop_c, full_c, empty_c;
    logic [FRAME_W-1:0]   head_c;
    logic [FRAME_LEN-1:0] frame_c;

    link_tx_fifo #(
        .W     (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .LINK_CLK (LINK_CLK),
        .RESETN   (RESETN),
        .push     (push_c),
        .pop      (pop_c),
        .wr_data  (TR_DATA),
        .rd_data  (head_c),
        .full     (full_c),
        .empty    (empty_c),
        .level    (LEVEL)
    );

`ifdef LINK_FRAME_TX_PARITY_EN
    assign frame_c = {^head_c, head_c};
`else
    assign frame_c = head_c;
`endif

    assign TR_READY = (state_q != ST_INIT) && !full_c;
    assign push_c   = DATA_READY && TR_READY;
    assign BUSY     = (state_q == ST_SHIFT) || (state_q == ST_GAP) || !empty_c;
    assign S_OUT    = s_out_q;
    assign SYNC     = sync_q;

    always_ff @(posedge LINK_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            shift_q <= '0;
            s_out_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            s_out_q <= s_out_d;
            sync_q  <= sync_d;
        end
    end

    // Frame boundaries reload the shifter straight from the FIFO head so frames run back to back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        s_out_d = 1'b0;
        sync_d  = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = frame_c;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                s_out_d = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    sync_d = 1'b1;
                    cnt_d  = '0;
                    if (GAP_CYCLES != 0) begin
                        state_d = ST_GAP;
                    end else if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = frame_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = frame_c;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule
